pcm_ahb_writer: RTL and testbench

PCM_AHB_WRITER -- requirements
Module: pcm_ahb_writer

---
 rtl/ahb_pkg.sv | 32 +++
 rtl/pcm_word_fifo.sv | 56 +++++
 rtl/pcm_ahb_writer.sv | 155 +++++++++++++++
 tb/tb_pcm_ahb_writer.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, writer FSM states and the buffered PCM word layout.
// Latency: none (definitions only).
// Backpressure: not applicable.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE     = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    // Writer FSM: one data word per ADDR/DATA pair, plus a trailing STOP write.
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        STOP_ADDR_PH,
        STOP_DATA_PH
    } wr_state_t;

    // One buffered word: stereo sample plus end-of-stream marker (33 bits).
    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } pcm_word_t;

    // Left channel goes in the upper half-word.
    function automatic logic [31:0] pack_sample(input logic [15:0] left, input logic [15:0] right);
        return {left, right};
    endfunction

endpackage

// File: rtl/pcm_word_fifo.sv
// Small synchronous FIFO holding packed PCM words for the AHB writer.
// Latency: a pushed word is visible at the head after one clock edge.
// Backpressure: push ignored when full, pop ignored when empty; full/empty exported.
module pcm_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array; contents are don't-care after reset since count gates reads.
    always_ff @(posedge HCLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally (power-of-two depth); simultaneous push+pop keeps count.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pcm_ahb_writer.sv
// Streams stereo PCM samples into single AHB word writes, then one STOP write at end of stream.
// Latency: sample accepted at edge k shows HTRANS=NONSEQ after edge k+1; 3 cycles per word at zero wait.
// Backpressure: s_ready drops when the word FIFO is full or a final sample awaits its STOP write.
module pcm_ahb_writer
    import ahb_pkg::*;
#(
    parameter logic [31:0] DATA_ADDR  = 32'h4000_0014,
    parameter logic [31:0] STOP_ADDR  = 32'h4000_0004,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_left,
    input  logic [15:0] s_right,
    input  logic        s_last,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy,
    output logic        err
);

    wr_state_t   state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] hwdata_q, hwdata_d;
    pcm_word_t   word_q, word_d;
    logic        last_seen_q, last_seen_d;
    logic        err_q, err_d;

    logic        push, pop;
    logic        fifo_full, fifo_empty;
    pcm_word_t   fifo_wdata, fifo_rdata;

    // No new samples once the final one is in, until its STOP write has finished.
    assign s_ready    = !HRESET && !fifo_full && !last_seen_q;
    assign push       = s_valid && s_ready;
    assign fifo_wdata = {s_last, pack_sample(s_left, s_right)};

    pcm_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pcm_word_t))
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state and registered-output logic for the single-outstanding-transfer master.
    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwdata_d    = hwdata_q;
        word_d      = word_q;
        err_d       = err_q;
        last_seen_d = last_seen_q;
        pop         = 1'b0;

        if (push && s_last) begin
            last_seen_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    word_d   = fifo_rdata;
                    haddr_d  = DATA_ADDR;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = word_q.data;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (HREADY) begin
                    if (HRESP) err_d = 1'b1;
                    if (word_q.last) begin
                        haddr_d  = STOP_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        state_d  = STOP_ADDR_PH;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            STOP_ADDR_PH: begin
                if (HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = 32'h0;
                    state_d  = STOP_DATA_PH;
                end
            end
            STOP_DATA_PH: begin
                if (HREADY) begin
                    if (HRESP) err_d = 1'b1;
                    last_seen_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bus-output registers; reset drops any in-flight transfer without a STOP.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwdata_q    <= '0;
            word_q      <= '0;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwdata_q    <= hwdata_d;
            word_q      <= word_d;
            last_seen_q <= last_seen_d;
            err_q       <= err_d;
        end
    end

    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWDATA = hwdata_q;
    assign HWRITE = 1'b1;
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_DATA_PRIV;
    assign err    = err_q;
    assign busy   = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pcm_ahb_writer.sv
// Scoreboard bench for pcm_ahb_writer: expected writes queued at sample acceptance, checked at bus completion.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: s_ready honoured by the stream driver; HREADY driven directly or by a wait-state generator.
module tb_pcm_ahb_writer;

    localparam logic [31:0] DATA_A = 32'h4000_0014;
    localparam logic [31:0] STOP_A = 32'h4000_0004;

    logic        HCLK;
    logic        HRESET;
    logic        s_valid, s_ready, s_last;
    logic [15:0] s_left, s_right;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HREADY, HRESP;
    logic        busy, err;

    int checks = 0;
    int errors = 0;
    int writes = 0;

    logic [63:0] exp_q [$];
    logic [63:0] mon_e;
    bit          mon_pend;
    logic [31:0] mon_addr;
    bit          prev_addr_wait, prev_data_wait;
    logic [31:0] prev_haddr, prev_hwdata;

    logic        hready_tb, ws_en, ws_hready;
    int          ws_cnt;
    logic        err_en;
    logic [31:0] err_word;

    int          tx_idx, tx_n;
    bit          tx_mark_last;
    logic [15:0] tx_lbase, tx_rbase;

    assign HREADY = ws_en ? ws_hready : hready_tb;
    assign HRESP  = err_en && (HWDATA === err_word);

    pcm_ahb_writer dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_left  (s_left),
        .s_right (s_right),
        .s_last  (s_last),
        .HADDR   (HADDR),
        .HTRANS  (HTRANS),
        .HWRITE  (HWRITE),
        .HSIZE   (HSIZE),
        .HBURST  (HBURST),
        .HPROT   (HPROT),
        .HWDATA  (HWDATA),
        .HREADY  (HREADY),
        .HRESP   (HRESP),
        .busy    (busy),
        .err     (err)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Wait-state generator: three low cycles then one high, repeating.
    initial begin
        ws_hready = 1'b0;
        ws_cnt    = 0;
        forever begin
            @(posedge HCLK);
            #1;
            if (ws_cnt >= 3) begin
                ws_hready = 1'b1;
                ws_cnt    = 0;
            end else begin
                ws_hready = 1'b0;
                ws_cnt++;
            end
        end
    end

    // Bus monitor: hold checks during wait states and scoreboard compare at data completion.
    initial begin
        mon_pend       = 0;
        prev_addr_wait = 0;
        prev_data_wait = 0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                mon_pend       = 0;
                prev_addr_wait = 0;
                prev_data_wait = 0;
            end else begin
                if (prev_addr_wait) begin
                    checks++;
                    if (HTRANS !== 2'b10 || HADDR !== prev_haddr) begin
                        errors++;
                        $display("FAIL addr_hold: HTRANS=%b HADDR=%h, required 10 %h", HTRANS, HADDR, prev_haddr);
                    end
                end
                if (prev_data_wait) begin
                    checks++;
                    if (HWDATA !== prev_hwdata) begin
                        errors++;
                        $display("FAIL data_hold: HWDATA=%h, required %h", HWDATA, prev_hwdata);
                    end
                end
                prev_addr_wait = 0;
                prev_data_wait = 0;
                if (mon_pend) begin
                    if (HREADY) begin
                        mon_pend = 0;
                        writes++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_write: addr=%h data=%h, required none", mon_addr, HWDATA);
                        end else begin
                            mon_e = exp_q.pop_front();
                            if ({mon_addr, HWDATA} !== mon_e) begin
                                errors++;
                                $display("FAIL write_order: got %h/%h, required %h/%h",
                                         mon_addr, HWDATA, mon_e[63:32], mon_e[31:0]);
                            end
                        end
                    end else begin
                        prev_data_wait = 1;
                        prev_hwdata    = HWDATA;
                    end
                end else if (HTRANS === 2'b10) begin
                    if (HREADY) begin
                        mon_pend = 1;
                        mon_addr = HADDR;
                    end else begin
                        prev_addr_wait = 1;
                        prev_haddr     = HADDR;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic start_stream(input int n, input logic [15:0] lb, input logic [15:0] rb, input bit mark);
        tx_idx       = 0;
        tx_n         = n;
        tx_lbase     = lb;
        tx_rbase     = rb;
        tx_mark_last = mark;
    endtask

    // One cycle of the stream driver; called at rising edge + 1, returns at the next rising edge + 1.
    task automatic tick();
        if (tx_idx < tx_n) begin
            s_valid = 1'b1;
            s_left  = tx_lbase + 16'(tx_idx);
            s_right = tx_rbase + 16'(tx_idx);
            s_last  = tx_mark_last && (tx_idx == tx_n - 1);
        end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
        @(negedge HCLK);
        if (s_valid && s_ready) begin
            exp_q.push_back({DATA_A, s_left, s_right});
            if (s_last) exp_q.push_back({STOP_A, 32'h0});
            tx_idx++;
        end
        @(posedge HCLK);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_stream(input int budget);
        int n = 0;
        while (tx_idx < tx_n && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (tx_idx != tx_n) begin
            errors++;
            $display("FAIL stream_accept: accepted %0d, required %0d", tx_idx, tx_n);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: busy=%b pending=%0d, required busy=0 pending=0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b0;
        #1;
        HRESET = 1'b1;
        #1;
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: HTRANS=%b HADDR=%h HWDATA=%h, required 00/0/0", HTRANS, HADDR, HWDATA);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b err=%b s_ready=%b, required 0/0/0", busy, err, s_ready);
        end
        checks++;
        if (HWRITE !== 1'b1 || HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0011) begin
            errors++;
            $display("FAIL const_ctrl: %b %b %b %b, required 1 010 000 0011", HWRITE, HSIZE, HBURST, HPROT);
        end
        @(negedge HCLK);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: s_ready=%b, required 1", s_ready);
        end
    endtask

    task automatic test_single();
        int w0 = writes;
        start_stream(1, 16'h1234, 16'hABCD, 1);
        tick();
        checks++;
        if (tx_idx != 1 || HTRANS !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: acc=%0d HTRANS=%b busy=%b, required 1/00/1", tx_idx, HTRANS, busy);
        end
        @(posedge HCLK);
        #1;
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== DATA_A) begin
            errors++;
            $display("FAIL single_latency: HTRANS=%b HADDR=%h, required 10 %h", HTRANS, HADDR, DATA_A);
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_gate: s_ready=%b, required 0", s_ready);
        end
        drain(100);
        checks++;
        if (writes - w0 != 2 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_count: writes=%0d s_ready=%b, required 2/1", writes - w0, s_ready);
        end
    endtask

    task automatic test_back_to_back();
        int w0 = writes;
        start_stream(6, 16'h0100, 16'h8000, 1);
        run_stream(100);
        drain(200);
        checks++;
        if (writes - w0 != 7) begin
            errors++;
            $display("FAIL b2b_count: writes=%0d, required 7", writes - w0);
        end
    endtask

    task automatic test_backpressure();
        int w0 = writes;
        logic [31:0] a0, d0;
        logic [1:0]  t0;
        hready_tb = 1'b0;
        start_stream(8, 16'h2000, 16'h3000, 1);
        repeat (20) tick();
        checks++;
        if (tx_idx != 5 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepts: accepted=%0d s_ready=%b, required 5/0", tx_idx, s_ready);
        end
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== DATA_A) begin
            errors++;
            $display("FAIL bp_addr: HTRANS=%b HADDR=%h, required 10 %h", HTRANS, HADDR, DATA_A);
        end
        a0 = HADDR;
        t0 = HTRANS;
        d0 = HWDATA;
        repeat (5) tick();
        checks++;
        if (HADDR !== a0 || HTRANS !== t0 || HWDATA !== d0 || tx_idx != 5) begin
            errors++;
            $display("FAIL bp_stable: %h %b %h acc=%0d, required %h %b %h acc=5", HADDR, HTRANS, HWDATA, tx_idx, a0, t0, d0);
        end
        hready_tb = 1'b1;
        run_stream(200);
        drain(300);
        checks++;
        if (writes - w0 != 9) begin
            errors++;
            $display("FAIL bp_count: writes=%0d, required 9", writes - w0);
        end
    endtask

    task automatic test_wait_states();
        int w0 = writes;
        ws_en = 1'b1;
        start_stream(5, 16'h4000, 16'h5000, 1);
        run_stream(400);
        drain(600);
        ws_en = 1'b0;
        checks++;
        if (writes - w0 != 6) begin
            errors++;
            $display("FAIL ws_count: writes=%0d, required 6", writes - w0);
        end
    endtask

    task automatic test_error();
        int w0 = writes;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_pre: err=%b, required 0", err);
        end
        err_en   = 1'b1;
        err_word = {16'h6001, 16'h7001};
        start_stream(3, 16'h6000, 16'h7000, 1);
        run_stream(100);
        drain(200);
        checks++;
        if (err !== 1'b1 || writes - w0 != 4) begin
            errors++;
            $display("FAIL err_set: err=%b writes=%0d, required 1/4", err, writes - w0);
        end
        err_en = 1'b0;
        repeat (5) @(posedge HCLK);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
    endtask

    task automatic test_reset_mid_data();
        int w0;
        int nonseq = 0;
        hready_tb = 1'b0;
        start_stream(4, 16'h8000, 16'h9000, 0);
        repeat (10) tick();
        checks++;
        if (tx_idx != 4) begin
            errors++;
            $display("FAIL rst_fill: accepted=%0d, required 4", tx_idx);
        end
        hready_tb = 1'b1;
        @(posedge HCLK);
        #1;
        hready_tb = 1'b0;
        checks++;
        if (HTRANS !== 2'b00 || HWDATA !== 32'h8000_9000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_data: HTRANS=%b HWDATA=%h busy=%b, required 00 80009000 1", HTRANS, HWDATA, busy);
        end
        #2;
        HRESET = 1'b1;
        #1;
        checks++;
        if (HTRANS !== 2'b00 || HWDATA !== 32'h0 || HADDR !== 32'h0) begin
            errors++;
            $display("FAIL rst_async_bus: HTRANS=%b HADDR=%h HWDATA=%h, required 00/0/0", HTRANS, HADDR, HWDATA);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_flags: busy=%b err=%b s_ready=%b, required 0/0/0", busy, err, s_ready);
        end
        exp_q.delete();
        @(posedge HCLK);
        #1;
        HRESET    = 1'b0;
        hready_tb = 1'b1;
        w0 = writes;
        repeat (20) begin
            @(posedge HCLK);
            #1;
            if (HTRANS === 2'b10) nonseq++;
        end
        checks++;
        if (nonseq != 0 || writes != w0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_quiet: nonseq=%0d writes=%0d busy=%b, required 0/0/0", nonseq, writes - w0, busy);
        end
    endtask

    task automatic test_last_gating();
        int w0 = writes;
        int bad = 0;
        int n = 0;
        start_stream(2, 16'hA000, 16'hB000, 1);
        run_stream(50);
        while (busy && n < 100) begin
            if (s_ready !== 1'b0) bad++;
            @(posedge HCLK);
            #1;
            n++;
        end
        checks++;
        if (bad != 0 || busy !== 1'b0 || n < 3) begin
            errors++;
            $display("FAIL last_gate: early_ready=%0d busy=%b cycles=%0d, required 0/0/>=3", bad, busy, n);
        end
        checks++;
        if (s_ready !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL last_release: s_ready=%b pending=%0d, required 1/0", s_ready, exp_q.size());
        end
        start_stream(3, 16'hC000, 16'hD000, 1);
        run_stream(100);
        drain(200);
        checks++;
        if (writes - w0 != 7) begin
            errors++;
            $display("FAIL second_stream: writes=%0d, required 7", writes - w0);
        end
    endtask

    initial begin
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_left    = '0;
        s_right   = '0;
        hready_tb = 1'b1;
        ws_en     = 1'b0;
        err_en    = 1'b0;
        err_word  = '0;
        tx_idx    = 0;
        tx_n      = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wait_states();
        test_error();
        test_reset_mid_data();
        test_last_gating();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
